// File: rtl/data_mem_if.sv
// Core-side data port plus the TX byte stream of the data memory system.
// Master is the core/system side; slave is data_mem.
interface data_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata_raw;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [3:0]  mem_byte_en;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output mem_addr, mem_wdata, mem_read_req, mem_write_req, mem_byte_en, tx_ready,
    input  mem_rdata_raw, tx_valid, tx_data
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read_req, mem_write_req, mem_byte_en, tx_ready,
    output mem_rdata_raw, tx_valid, tx_data
  );
endinterface

// File: rtl/data_mem.sv
// Data-side memory: word RAM with lane steering, MMIO block with TX byte FIFO,
// 64-bit cycle counter with tear-free hi shadow, and a sticky HALT register.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int unsigned TXQ_DEPTH   = 8,
  // Reset value of the cycle counter; nonzero only to start near a carry boundary.
  parameter logic [63:0] CYCLE_INIT  = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_if.slave        bus,
  output logic             halt,
  output logic [31:0]      halt_code,
  output logic             misalign_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int QAW   = $clog2(TXQ_DEPTH);

  localparam logic [5:0] REG_TXDATA = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_CYC_LO = 6'h02;
  localparam logic [5:0] REG_CYC_HI = 6'h03;
  localparam logic [5:0] REG_HALT   = 6'h04;

  logic [1:0]       off;
  logic             is_half;
  logic             is_word;
  logic             misaligned;
  logic [3:0]       lanes;
  logic [31:0]      wdata_sh;
  logic [31:0]      size_mask;
  logic             wr_ok;
  logic             is_mmio;
  logic [29:0]      mmio_word;
  logic             in_window;
  logic [5:0]       reg_sel;
  logic             mmio_wr;
  logic             ram_we;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             full;
  logic             empty;
  logic             ovf_clear;
  logic             halt_wr;
  logic             cyc_lo_rd;
  logic [IDX_W-1:0] ram_idx;

  logic [31:0]      ram [DEPTH_WORDS];
  logic [7:0]       txq [TXQ_DEPTH];
  logic [QAW:0]     wr_ptr;
  logic [QAW:0]     rd_ptr;
  logic             overflow;
  logic [63:0]      cycle;
  logic [31:0]      cyc_hi_shadow;
  logic [31:0]      mmio_rword;
  logic [31:0]      rword;
  logic [31:0]      rdata;

  assign off        = bus.mem_addr[1:0];
  assign is_half    = (bus.mem_byte_en == 4'b0011);
  assign is_word    = (bus.mem_byte_en == 4'b1111);
  assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign lanes      = bus.mem_byte_en << off;
  assign wdata_sh   = bus.mem_wdata << {off, 3'b000};
  assign size_mask  = {{8{bus.mem_byte_en[3]}}, {8{bus.mem_byte_en[2]}},
                       {8{bus.mem_byte_en[1]}}, {8{bus.mem_byte_en[0]}}};
  assign wr_ok      = bus.mem_write_req & ~misaligned;

  // Register file is word-decoded; anything past the 64-word window reads 0.
  assign is_mmio    = (bus.mem_addr >= MMIO_BASE);
  assign mmio_word  = bus.mem_addr[31:2] - MMIO_BASE[31:2];
  assign in_window  = (mmio_word[29:6] == 24'd0);
  assign reg_sel    = mmio_word[5:0];
  assign mmio_wr    = wr_ok & is_mmio & in_window;
  assign ram_we     = wr_ok & ~is_mmio;
  assign ram_idx    = bus.mem_addr[IDX_W+1:2];

  assign push       = mmio_wr & (reg_sel == REG_TXDATA) & (off == 2'b00);
  assign ovf_clear  = mmio_wr & (reg_sel == REG_STATUS) & lanes[0] & wdata_sh[2];
  assign halt_wr    = mmio_wr & (reg_sel == REG_HALT);
  assign cyc_lo_rd  = bus.mem_read_req & ~misaligned & is_mmio & in_window &
                      (reg_sel == REG_CYC_LO);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) ram[ram_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                        (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
  assign bus.tx_valid = ~empty;
  assign bus.tx_data  = txq[rd_ptr[QAW-1:0]];
  assign pop          = ~empty & bus.tx_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push_ok      = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) txq[wr_ptr[QAW-1:0]] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (QAW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (QAW+1)'(1);
      if (push & full & ~pop) overflow <= 1'b1;
      else if (ovf_clear)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle         <= CYCLE_INIT;
      cyc_hi_shadow <= 32'd0;
      halt          <= 1'b0;
      halt_code     <= 32'd0;
      misalign_err  <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      if (cyc_lo_rd) cyc_hi_shadow <= cycle[63:32];
      if (halt_wr && !halt) begin
        halt      <= 1'b1;
        halt_code <= bus.mem_wdata;
      end
      if ((bus.mem_read_req | bus.mem_write_req) && misaligned) misalign_err <= 1'b1;
    end
  end

  // Reads see pre-edge state, so a same-cycle write never affects the returned data.
  always_comb begin
    mmio_rword = 32'd0;
    if (in_window) begin
      case (reg_sel)
        REG_STATUS: mmio_rword = {29'd0, overflow, full, empty};
        REG_CYC_LO: mmio_rword = cycle[31:0];
        REG_CYC_HI: mmio_rword = cyc_hi_shadow;
        default:    mmio_rword = 32'd0;
      endcase
    end
    rword = is_mmio ? mmio_rword : ram[ram_idx];
    rdata = 32'd0;
    if (bus.mem_read_req && !misaligned) rdata = (rword >> {off, 3'b000}) & size_mask;
  end

  assign bus.mem_rdata_raw = rdata;

endmodule
